// File: rtl/lemmings_ctrl_if.sv
// Sensor inputs and status outputs of one Lemming controller.
interface lemmings_ctrl_if;
    logic bump_left;
    logic bump_right;
    logic small_bump_left;
    logic small_bump_right;
    logic ground;
    logic dig;
    logic walk_left;
    logic walk_right;
    logic aah;
    logic digging;
    logic jumping;

    // Game world / stimulus side: drives sensors, observes status
    modport master (
        output bump_left, bump_right, small_bump_left, small_bump_right, ground, dig,
        input  walk_left, walk_right, aah, digging, jumping
    );

    // Controller side
    modport slave (
        input  bump_left, bump_right, small_bump_left, small_bump_right, ground, dig,
        output walk_left, walk_right, aah, digging, jumping
    );
endinterface

// File: rtl/lemmings_ctrl.sv
// Moore behaviour controller for one Lemming: walk, turn, hop, fall, dig, splat.
module lemmings_ctrl #(
    parameter int unsigned SPLAT_LIMIT = 20,
    parameter int unsigned JUMP_CYCLES = 2,
    parameter int unsigned CNT_W       = 5
) (
    input logic            clk,
    input logic            areset,
    lemmings_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] SplatLim = CNT_W'(SPLAT_LIMIT);
    localparam logic [CNT_W-1:0] JumpLast = CNT_W'(JUMP_CYCLES - 1);

    typedef enum logic [3:0] {
        StWl, StWr, StFl, StFr, StDl, StDr, StJl, StJr, StSplat
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] fall_q, fall_d;
    logic [CNT_W-1:0] jump_q, jump_d;
    // {jumping, digging, aah, walk_right, walk_left}
    logic [4:0]       out_q, out_d;

    // Next-state, counter update and output decode of the next state
    always_comb begin
        state_d = state_q;
        fall_d  = fall_q;
        jump_d  = jump_q;
        out_d   = 5'b00000;

        case (state_q)
            StWl: begin
                if (!bus.ground) begin
                    state_d = StFl;
                    fall_d  = '0;
                end else if (bus.dig) begin
                    state_d = StDl;
                end else if (bus.bump_left) begin
                    state_d = StWr;
                end else if (bus.small_bump_left) begin
                    state_d = StJl;
                    jump_d  = '0;
                end
            end
            StWr: begin
                if (!bus.ground) begin
                    state_d = StFr;
                    fall_d  = '0;
                end else if (bus.dig) begin
                    state_d = StDr;
                end else if (bus.bump_right) begin
                    state_d = StWl;
                end else if (bus.small_bump_right) begin
                    state_d = StJr;
                    jump_d  = '0;
                end
            end
            StFl, StFr: begin
                if (bus.ground) begin
                    if (fall_q >= SplatLim) begin
                        state_d = StSplat;
                    end else begin
                        state_d = (state_q == StFl) ? StWl : StWr;
                    end
                end else if (fall_q != '1) begin
                    fall_d = fall_q + 1'b1;
                end
            end
            StDl, StDr: begin
                if (!bus.ground) begin
                    state_d = (state_q == StDl) ? StFl : StFr;
                    fall_d  = '0;
                end
            end
            StJl, StJr: begin
                // Ground only matters on the final jump cycle
                if (jump_q == JumpLast) begin
                    if (bus.ground) begin
                        state_d = (state_q == StJl) ? StWl : StWr;
                    end else begin
                        state_d = (state_q == StJl) ? StFl : StFr;
                        fall_d  = '0;
                    end
                end else begin
                    jump_d = jump_q + 1'b1;
                end
            end
            StSplat: state_d = StSplat;
            default: state_d = StWl;
        endcase

        case (state_d)
            StWl:       out_d = 5'b00001;
            StWr:       out_d = 5'b00010;
            StFl, StFr: out_d = 5'b00100;
            StDl, StDr: out_d = 5'b01000;
            StJl, StJr: out_d = 5'b10000;
            default:    out_d = 5'b00000;
        endcase
    end

    // State, counters and registered outputs; reset overrides everything
    always_ff @(posedge clk) begin
        if (!areset) begin
            state_q <= StWl;
            fall_q  <= '0;
            jump_q  <= '0;
            out_q   <= 5'b00001;
        end else begin
            state_q <= state_d;
            fall_q  <= fall_d;
            jump_q  <= jump_d;
            out_q   <= out_d;
        end
    end

    assign bus.walk_left  = out_q[0];
    assign bus.walk_right = out_q[1];
    assign bus.aah        = out_q[2];
    assign bus.digging    = out_q[3];
    assign bus.jumping    = out_q[4];

endmodule

// File: tb/tb_lemmings_ctrl.sv
// Directed self-checking bench for lemmings_ctrl.
module tb_lemmings_ctrl;

    localparam logic [4:0] OWL = 5'b00001;
    localparam logic [4:0] OWR = 5'b00010;
    localparam logic [4:0] OF  = 5'b00100;
    localparam logic [4:0] OD  = 5'b01000;
    localparam logic [4:0] OJ  = 5'b10000;
    localparam logic [4:0] OSP = 5'b00000;

    logic clk;
    logic areset;
    int   n_checks;
    int   n_err;

    lemmings_ctrl_if bus ();

    lemmings_ctrl #(
        .SPLAT_LIMIT(20),
        .JUMP_CYCLES(2),
        .CNT_W      (5)
    ) dut (
        .clk   (clk),
        .areset(areset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [4:0] outs = {bus.jumping, bus.digging, bus.aah, bus.walk_right, bus.walk_left};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [4:0] exp);
        n_checks++;
        assert (outs === exp)
        else begin
            n_err++;
            $error("FAIL %s: got %b expected %b", tag, outs, exp);
        end
    endtask

    task automatic clear_side();
        bus.bump_left        = 1'b0;
        bus.bump_right       = 1'b0;
        bus.small_bump_left  = 1'b0;
        bus.small_bump_right = 1'b0;
        bus.dig              = 1'b0;
    endtask

    // Hold ground low for n edges, then land; expect n cycles of aah then `land`
    task automatic fall_for(input int n, input logic [4:0] land, input string tag);
        bus.ground = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            check({tag, "_aah"}, OF);
        end
        bus.ground = 1'b1;
        tick();
        check({tag, "_land"}, land);
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        areset   = 1'b0;
        bus.ground = 1'b1;
        clear_side();

        tick();
        check("reset", OWL);
        areset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_wl", OWL);
        end

        // Turn right; further left bumps ignored while walking right
        bus.bump_left = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("turn_wr", OWR);
        end
        bus.bump_left = 1'b0;

        // Repeated hop while small bump held
        bus.small_bump_right = 1'b1;
        for (int r = 0; r < 2; r++) begin
            tick(); check("jr1", OJ);
            tick(); check("jr2", OJ);
            tick(); check("jr_wr", OWR);
        end
        bus.small_bump_right = 1'b0;
        tick(); check("wr_hold", OWR);

        bus.bump_right = 1'b1;
        tick(); check("turn_wl", OWL);
        bus.bump_right = 1'b0;

        // Input ignored after hop starts
        bus.small_bump_left = 1'b1;
        tick(); check("jl1", OJ);
        bus.small_bump_left = 1'b0;
        bus.bump_left = 1'b1;
        bus.dig = 1'b1;
        tick(); check("jl2", OJ);
        clear_side();
        tick(); check("jl_wl", OWL);
        tick(); check("wl_hold", OWL);

        // Full bump beats small bump
        bus.bump_left = 1'b1;
        bus.small_bump_left = 1'b1;
        tick(); check("bump_vs_small", OWR);
        clear_side();
        tick(); check("bump_vs_small_hold", OWR);

        // Fall while walking right keeps direction
        fall_for(3, OWR, "fall_r3");
        bus.bump_right = 1'b1;
        tick(); check("back_wl", OWL);
        bus.bump_right = 1'b0;

        fall_for(5, OWL, "fall5");
        fall_for(20, OWL, "fall20");
        fall_for(21, OSP, "fall21");

        // Splat is absorbing
        bus.bump_left = 1'b1;
        bus.dig = 1'b1;
        bus.ground = 1'b0;
        tick(); check("splat_hold1", OSP);
        bus.ground = 1'b1;
        tick(); check("splat_hold2", OSP);
        clear_side();
        areset = 1'b0;
        tick(); check("reset_from_splat", OWL);
        areset = 1'b1;

        // Fall beats dig; then digging ignores dig and bumps
        bus.ground = 1'b0;
        bus.dig = 1'b1;
        tick(); check("fall_beats_dig", OF);
        bus.ground = 1'b1;
        bus.dig = 1'b0;
        tick(); check("fall_beats_dig_land", OWL);

        bus.dig = 1'b1;
        bus.bump_left = 1'b1;
        tick(); check("dig_beats_bump", OD);
        bus.small_bump_left = 1'b1;
        tick(); check("dig_ignore", OD);
        clear_side();
        tick(); check("dig_hold", OD);
        fall_for(25, OSP, "dig_fall25");

        areset = 1'b0;
        tick(); check("reset2", OWL);
        areset = 1'b1;

        // Jump exits into a fall when ground missing at exit; mid-jump ground ignored
        bus.small_bump_left = 1'b1;
        tick(); check("jfall_j1", OJ);
        bus.small_bump_left = 1'b0;
        bus.ground = 1'b0;
        tick(); check("jfall_j2", OJ);
        tick(); check("jfall_aah", OF);
        bus.ground = 1'b1;
        tick(); check("jfall_land", OWL);

        // Reset mid-fall, even with no ground beneath
        bus.ground = 1'b0;
        tick(); check("midfall", OF);
        tick(); check("midfall2", OF);
        areset = 1'b0;
        tick(); check("reset_midfall", OWL);
        areset = 1'b1;
        bus.ground = 1'b1;
        tick(); check("after_reset", OWL);
        fall_for(20, OWL, "post_reset_fall20");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
